// File: rtl/fdd_arb_pkg.sv
// Shared types and constants for the floppy-to-SD sector request arbiter.
package fdd_arb_pkg;

  localparam int NCLI          = 2;
  localparam int LBA_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    XFER,
    DONE
  } arb_state_e;

endpackage

// File: rtl/fdd_rr_pick.sv
// Combinational round-robin picker for the two floppy clients.
module fdd_rr_pick
  import fdd_arb_pkg::*;
(
  input  logic [NCLI-1:0] req,
  input  logic            last,
  output logic            valid,
  output logic            win
);

  // On a tie the client that was not served last wins.
  always_comb begin
    valid = |req;
    win   = 1'b0;
    if (req[0] && req[1]) begin
      win = ~last;
    end else if (req[1]) begin
      win = 1'b1;
    end
  end

endmodule

// File: rtl/fdd_sd_arbiter.sv
// Two-client SD sector arbiter: latches the winner's request and forwards the host handshake.
// Optional host-ack watchdog enabled by defining FDD_ARB_TIMEOUT_EN.
module fdd_sd_arbiter
  import fdd_arb_pkg::*;
#(
  parameter int          LBA_W          = LBA_W_DEFAULT,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd16_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [LBA_W-1:0] c0_lba,
  input  logic             c0_rd,
  input  logic             c0_wr,
  output logic             c0_ack,
  output logic             c0_buff_wr,
  input  logic [7:0]       c0_buff_din,
  input  logic [LBA_W-1:0] c1_lba,
  input  logic             c1_rd,
  input  logic             c1_wr,
  output logic             c1_ack,
  output logic             c1_buff_wr,
  input  logic [7:0]       c1_buff_din,
  output logic [LBA_W-1:0] sd_lba,
  output logic             sd_rd,
  output logic             sd_wr,
  input  logic             sd_ack,
  input  logic             sd_buff_wr,
  output logic [7:0]       sd_buff_din,
  output logic             grant,
  output logic             busy,
  output logic             err
);

  arb_state_e       state_q, state_d;
  logic [LBA_W-1:0] sd_lba_q, sd_lba_d;
  logic             op_wr_q, op_wr_d;
  logic             grant_q, grant_d;
  logic             sd_rd_q, sd_rd_d;
  logic             sd_wr_q, sd_wr_d;
  logic             pick_valid;
  logic             pick_win;
  logic             in_xfer;

`ifdef FDD_ARB_TIMEOUT_EN
  logic [23:0]      cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  fdd_rr_pick u_pick (
    .req   ({c1_rd | c1_wr, c0_rd | c0_wr}),
    .last  (grant_q),
    .valid (pick_valid),
    .win   (pick_win)
  );

  always_comb begin
    state_d  = state_q;
    sd_lba_d = sd_lba_q;
    op_wr_d  = op_wr_q;
    grant_d  = grant_q;
    sd_rd_d  = 1'b0;
    sd_wr_d  = 1'b0;
`ifdef FDD_ARB_TIMEOUT_EN
    cnt_d    = cnt_q;
    err_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d  = pick_win;
          sd_lba_d = pick_win ? c1_lba : c0_lba;
          op_wr_d  = pick_win ? c1_wr : c0_wr;
          state_d  = REQ;
`ifdef FDD_ARB_TIMEOUT_EN
          cnt_d    = 24'd0;
`endif
        end
      end
      REQ: begin
        // Ack is examined first so an ack on the watchdog's last cycle still wins.
        if (sd_ack) begin
          state_d = XFER;
`ifdef FDD_ARB_TIMEOUT_EN
        end else if (cnt_q == TIMEOUT_CYCLES - 24'd1) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + 24'd1;
          sd_rd_d = ~op_wr_q;
          sd_wr_d = op_wr_q;
`else
        end else begin
          sd_rd_d = ~op_wr_q;
          sd_wr_d = op_wr_q;
`endif
        end
      end
      XFER: begin
        if (!sd_ack) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      sd_lba_q <= '0;
      op_wr_q  <= 1'b0;
      grant_q  <= 1'b1;
      sd_rd_q  <= 1'b0;
      sd_wr_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sd_lba_q <= sd_lba_d;
      op_wr_q  <= op_wr_d;
      grant_q  <= grant_d;
      sd_rd_q  <= sd_rd_d;
      sd_wr_q  <= sd_wr_d;
    end
  end

`ifdef FDD_ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= 24'd0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Forwarding is combinational so the host's byte strobes stay aligned with the client buffer.
  assign in_xfer     = (state_q == XFER);
  assign c0_ack      = in_xfer & ~grant_q & sd_ack;
  assign c1_ack      = in_xfer & grant_q & sd_ack;
  assign c0_buff_wr  = in_xfer & ~grant_q & sd_buff_wr;
  assign c1_buff_wr  = in_xfer & grant_q & sd_buff_wr;
  assign sd_buff_din = grant_q ? c1_buff_din : c0_buff_din;

  assign sd_lba = sd_lba_q;
  assign sd_rd  = sd_rd_q;
  assign sd_wr  = sd_wr_q;
  assign grant  = grant_q;
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_fdd_sd_arbiter.sv
// Scoreboard bench for fdd_sd_arbiter: a round-robin service-order model feeds an expected
// queue that a monitor checks whenever the arbiter raises a host request.
module tb_fdd_sd_arbiter;

  typedef struct {
    bit          cli;
    bit          wr;
    logic [31:0] lba;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] c0_lba, c1_lba;
  logic        c0_rd, c0_wr, c1_rd, c1_wr;
  logic        c0_ack, c1_ack, c0_buff_wr, c1_buff_wr;
  logic [7:0]  c0_buff_din, c1_buff_din;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr, sd_ack, sd_buff_wr;
  logic [7:0]  sd_buff_din;
  logic        grant, busy, err;

  int   n_vec = 0;
  int   n_bad = 0;
  exp_t exp_q[$];
  bit   last_m = 1'b1;
  int   strobes_next = 0;
  int   host_n = 0;
  bit   host_mute = 1'b0;
  bit   din_rand = 1'b1;

  fdd_sd_arbiter #(.LBA_W(32), .TIMEOUT_CYCLES(24'd8)) dut (
    .clk         (clk),
    .reset       (reset),
    .c0_lba      (c0_lba),
    .c0_rd       (c0_rd),
    .c0_wr       (c0_wr),
    .c0_ack      (c0_ack),
    .c0_buff_wr  (c0_buff_wr),
    .c0_buff_din (c0_buff_din),
    .c1_lba      (c1_lba),
    .c1_rd       (c1_rd),
    .c1_wr       (c1_wr),
    .c1_ack      (c1_ack),
    .c1_buff_wr  (c1_buff_wr),
    .c1_buff_din (c1_buff_din),
    .sd_lba      (sd_lba),
    .sd_rd       (sd_rd),
    .sd_wr       (sd_wr),
    .sd_ack      (sd_ack),
    .sd_buff_wr  (sd_buff_wr),
    .sd_buff_din (sd_buff_din),
    .grant       (grant),
    .busy        (busy),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input bit cli, input bit w0, input bit w1,
                          input logic [31:0] l0, input logic [31:0] l1);
    exp_t e;
    e.cli = cli;
    e.wr  = cli ? w1 : w0;
    e.lba = cli ? l1 : l0;
    exp_q.push_back(e);
  endtask

  // Raise client requests (caller sits on a falling edge) and predict the service order.
  task automatic apply_stimulus(input bit r0, input bit w0, input bit r1, input bit w1,
                                input logic [31:0] l0, input logic [31:0] l1);
    bit q0, q1, first;
    c0_lba = l0; c1_lba = l1;
    c0_rd = r0; c0_wr = w0; c1_rd = r1; c1_wr = w1;
    q0 = r0 | w0;
    q1 = r1 | w1;
    if (q0 && q1) begin
      first = ~last_m;
      push_exp(first, w0, w1, l0, l1);
      push_exp(~first, w0, w1, l0, l1);
      last_m = ~first;
    end else if (q0) begin
      push_exp(1'b0, w0, w1, l0, l1);
      last_m = 1'b0;
    end else if (q1) begin
      push_exp(1'b1, w0, w1, l0, l1);
      last_m = 1'b1;
    end
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      if (!busy && !(c0_rd | c0_wr | c1_rd | c1_wr)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_output("idle_wait_timeout", 1, 0);
    @(negedge clk);
  endtask

  // Host model: ack each request, emit a burst of byte strobes, and move the granted
  // client's LBA once the request is visible so late changes are exercised.
  initial begin
    sd_ack = 1'b0;
    sd_buff_wr = 1'b0;
    forever begin
      @(negedge clk);
      if (!host_mute && !reset && (sd_rd | sd_wr) && !sd_ack) begin
        host_n = (strobes_next > 0) ? strobes_next : int'($urandom_range(1, 6));
        if (grant) c1_lba = c1_lba + 32'd4;
        else       c0_lba = c0_lba + 32'd4;
        repeat ($urandom_range(0, 3)) @(negedge clk);
        sd_ack = 1'b1;
        @(negedge clk);
        for (int k = 0; k < host_n; k++) begin
          sd_buff_wr = 1'b1;
          @(negedge clk);
          sd_buff_wr = 1'b0;
          repeat ($urandom_range(0, 1)) @(negedge clk);
        end
        sd_ack = 1'b0;
      end
    end
  end

  // Clients drop their request once they see their ack.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (c0_ack) begin c0_rd = 1'b0; c0_wr = 1'b0; end
      if (c1_ack) begin c1_rd = 1'b0; c1_wr = 1'b0; end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #3;
      if (din_rand) begin
        c0_buff_din = 8'($urandom);
        c1_buff_din = 8'($urandom);
      end
    end
  end

  // Monitor: pop the expected transaction on each new host request and check routing.
  initial begin
    exp_t cur;
    bit   active = 1'b0, prev_req = 1'b0, prev_ack = 1'b0;
    int   strobe_cnt = 0;
    logic own_ack, own_bw, oth_ack, oth_bw;
    logic [7:0] own_din;
    cur.cli = 1'b0; cur.wr = 1'b0; cur.lba = '0;
    forever begin
      @(posedge clk); #1;
      if (reset) begin
        active = 1'b0; prev_req = 1'b0; prev_ack = 1'b0;
      end else begin
        if ((sd_rd | sd_wr) && !prev_req) begin
          if (exp_q.size() == 0) begin
            check_output("unexpected_request", 1, 0);
          end else begin
            cur = exp_q.pop_front();
            active = 1'b1;
            strobe_cnt = 0;
            check_output("req_grant", 64'(grant), 64'(cur.cli));
            check_output("req_op", {sd_rd, sd_wr}, {~cur.wr, cur.wr});
          end
        end
        if (active) begin
          own_ack = cur.cli ? c1_ack : c0_ack;
          own_bw  = cur.cli ? c1_buff_wr : c0_buff_wr;
          oth_ack = cur.cli ? c0_ack : c1_ack;
          oth_bw  = cur.cli ? c0_buff_wr : c1_buff_wr;
          own_din = cur.cli ? c1_buff_din : c0_buff_din;
          check_output("lba_stable", sd_lba, cur.lba);
          check_output("other_client_quiet", {oth_ack, oth_bw}, 2'b00);
          check_output("buff_wr_route", 64'(own_bw), 64'(sd_buff_wr));
          if (sd_buff_wr) begin
            strobe_cnt++;
            check_output("ack_route", 64'(own_ack), 64'd1);
            if (cur.wr) check_output("wr_data", sd_buff_din, own_din);
          end
          if (prev_ack && !sd_ack) begin
            check_output("strobe_count", strobe_cnt, host_n);
            check_output("no_err", 64'(err), 64'd0);
          end
          if (!busy) active = 1'b0;
        end
        prev_req = sd_rd | sd_wr;
        prev_ack = sd_ack;
      end
    end
  end

  initial begin
    #1ms;
    $display("[TB] FAIL global_timeout: simulation ran 1 ms, required completion");
    $fatal(1, "[TB] aborted");
  end

  initial begin
    reset = 1'b1;
    c0_lba = '0; c1_lba = '0;
    c0_rd = 1'b0; c0_wr = 1'b0; c1_rd = 1'b0; c1_wr = 1'b0;
    c0_buff_din = '0; c1_buff_din = '0;
    repeat (2) @(negedge clk);
    check_output("reset_outputs",
                 {sd_rd, sd_wr, sd_lba, c0_ack, c1_ack, c0_buff_wr, c1_buff_wr, grant, busy, err},
                 {2'b00, 32'h0, 4'b0000, 1'b1, 1'b0, 1'b0});
    reset = 1'b0;
    @(negedge clk);

    // Ties straight after reset: client 0 first, and again on the next tie.
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h100, 32'h200);
    wait_idle();
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h300, 32'h400);
    wait_idle();

    // Single read with a full sector and request-to-sd_rd latency.
    strobes_next = 512;
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h12, 32'h0);
    @(posedge clk); #1;
    check_output("lat_cycle1", {busy, sd_rd}, 2'b10);
    @(posedge clk); #1;
    check_output("lat_cycle2", {sd_rd, sd_lba}, {1'b1, 32'h12});
    wait_idle();
    strobes_next = 0;

    // Host model bumps c0_lba to 9 during REQ; sd_lba must stay 5.
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd5, 32'd0);
    wait_idle();

    din_rand = 1'b0;
    c0_buff_din = 8'h5A;
    c1_buff_din = 8'hA5;
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h40);
    wait_idle();
    din_rand = 1'b1;

    for (int r = 0; r < 30; r++) begin
      bit [1:0] who;
      bit [1:0] op0, op1;
      who = 2'($urandom_range(1, 3));
      op0 = 2'($urandom_range(1, 3));
      op1 = 2'($urandom_range(1, 3));
      apply_stimulus(who[0] & op0[0], who[0] & op0[1], who[1] & op1[0], who[1] & op1[1],
                     $urandom, $urandom);
      wait_idle();
    end

`ifdef FDD_ARB_TIMEOUT_EN
    begin
      int rd_cycles = 0;
      bit seen = 1'b0;
      host_mute = 1'b1;
      apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h33, 32'h0);
      push_exp(1'b0, 1'b0, 1'b0, 32'h33, 32'h0);
      for (int i = 0; i < 60; i++) begin
        @(posedge clk); #1;
        if (err) begin
          seen = 1'b1;
          check_output("timeout_drop", {sd_rd, sd_wr}, 2'b00);
          break;
        end
        if (sd_rd) rd_cycles++;
      end
      check_output("timeout_seen", 64'(seen), 64'd1);
      check_output("timeout_rd_cycles", rd_cycles, 7);
      @(posedge clk); #1;
      check_output("err_single_pulse", 64'(err), 64'd0);
      @(negedge clk);
      host_mute = 1'b0;
      wait_idle();
    end
`endif

    // Reset in the middle of a transfer while the host still holds ack.
    strobes_next = 30;
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h77);
    begin
      bit got = 1'b0;
      for (int i = 0; i < 100; i++) begin
        @(posedge clk); #1;
        if (c1_ack) begin got = 1'b1; break; end
      end
      check_output("xfer_reached", 64'(got), 64'd1);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_output("reset_mid_xfer",
                 {sd_rd, sd_wr, sd_lba, c0_ack, c1_ack, c0_buff_wr, c1_buff_wr, grant, busy, err},
                 {2'b00, 32'h0, 4'b0000, 1'b1, 1'b0, 1'b0});
    last_m = 1'b1;
    repeat (3) @(negedge clk);
    check_output("stale_ack_ignored", {c0_ack, c1_ack, c0_buff_wr, c1_buff_wr}, 4'b0000);
    for (int i = 0; i < 200 && sd_ack; i++) @(negedge clk);
    strobes_next = 0;
    reset = 1'b0;
    @(negedge clk);

    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h55, 32'h66);
    wait_idle();

    check_output("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
